// File: rtl/sys_cntr_rx.sv
`default_nettype none
// ============================================================================
// Module   : sys_cntr_rx
// Brief    : Receive-side system controller. Decodes UART command frames into
//            register-file and ALU operations and queues responses to TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sys_cntr_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [DATA_WIDTH-1:0]   RX_Data,
    input  logic                    RX_Valid,
    output logic [ADDR_WIDTH-1:0]   RF_Addr,
    output logic                    RF_WrEn,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    output logic                    RF_RdEn,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdValid,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_Out,
    input  logic                    ALU_Valid,
    output logic                    CLK_GATE_EN,
    input  logic                    FIFO_Full,
    output logic [DATA_WIDTH-1:0]   FIFO_WrData,
    output logic                    FIFO_WrEn
);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_wr_addr  = 4'd1;
    localparam logic [3:0] c_st_wr_data  = 4'd2;
    localparam logic [3:0] c_st_rd_addr  = 4'd3;
    localparam logic [3:0] c_st_rd_wait  = 4'd4;
    localparam logic [3:0] c_st_rd_send  = 4'd5;
    localparam logic [3:0] c_st_alu_a    = 4'd6;
    localparam logic [3:0] c_st_alu_b    = 4'd7;
    localparam logic [3:0] c_st_alu_fn   = 4'd8;
    localparam logic [3:0] c_st_alu_wait = 4'd9;
    localparam logic [3:0] c_st_send_lo  = 4'd10;
    localparam logic [3:0] c_st_send_hi  = 4'd11;

    localparam logic [DATA_WIDTH-1:0] c_cmd_wr     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_cmd_rd     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_cmd_alu_op = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_cmd_alu_nop = DATA_WIDTH'(8'hDD);

    logic [3:0]              r_state;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic [2*DATA_WIDTH-1:0] r_result;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state     <= c_st_idle;
            r_wr_addr   <= '0;
            r_rd_data   <= '0;
            r_result    <= '0;
            RF_Addr     <= '0;
            RF_WrEn     <= 1'b0;
            RF_WrData   <= '0;
            RF_RdEn     <= 1'b0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            FIFO_WrData <= '0;
            FIFO_WrEn   <= 1'b0;
        end else begin
            RF_WrEn   <= 1'b0;
            RF_RdEn   <= 1'b0;
            ALU_EN    <= 1'b0;
            FIFO_WrEn <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (RX_Valid) begin
                        case (RX_Data)
                            c_cmd_wr:      r_state <= c_st_wr_addr;
                            c_cmd_rd:      r_state <= c_st_rd_addr;
                            c_cmd_alu_op:  r_state <= c_st_alu_a;
                            c_cmd_alu_nop: r_state <= c_st_alu_fn;
                            default:       r_state <= c_st_idle;
                        endcase
                    end
                end

                c_st_wr_addr: begin
                    if (RX_Valid) begin
                        r_wr_addr <= RX_Data[ADDR_WIDTH-1:0];
                        r_state   <= c_st_wr_data;
                    end
                end

                c_st_wr_data: begin
                    if (RX_Valid) begin
                        RF_WrEn   <= 1'b1;
                        RF_Addr   <= r_wr_addr;
                        RF_WrData <= RX_Data;
                        r_state   <= c_st_idle;
                    end
                end

                c_st_rd_addr: begin
                    if (RX_Valid) begin
                        RF_RdEn <= 1'b1;
                        RF_Addr <= RX_Data[ADDR_WIDTH-1:0];
                        r_state <= c_st_rd_wait;
                    end
                end

                // Push straight from the read response when the FIFO has room,
                // so the byte leaves one cycle after RF_RdValid.
                c_st_rd_wait: begin
                    if (RF_RdValid) begin
                        r_rd_data <= RF_RdData;
                        if (!FIFO_Full) begin
                            FIFO_WrEn   <= 1'b1;
                            FIFO_WrData <= RF_RdData;
                            r_state     <= c_st_idle;
                        end else begin
                            r_state <= c_st_rd_send;
                        end
                    end
                end

                c_st_rd_send: begin
                    if (!FIFO_Full) begin
                        FIFO_WrEn   <= 1'b1;
                        FIFO_WrData <= r_rd_data;
                        r_state     <= c_st_idle;
                    end
                end

                c_st_alu_a: begin
                    if (RX_Valid) begin
                        RF_WrEn   <= 1'b1;
                        RF_Addr   <= '0;
                        RF_WrData <= RX_Data;
                        r_state   <= c_st_alu_b;
                    end
                end

                c_st_alu_b: begin
                    if (RX_Valid) begin
                        RF_WrEn   <= 1'b1;
                        RF_Addr   <= ADDR_WIDTH'(1);
                        RF_WrData <= RX_Data;
                        r_state   <= c_st_alu_fn;
                    end
                end

                c_st_alu_fn: begin
                    if (RX_Valid) begin
                        ALU_EN      <= 1'b1;
                        ALU_FUN     <= RX_Data[FUN_WIDTH-1:0];
                        CLK_GATE_EN <= 1'b1;
                        r_state     <= c_st_alu_wait;
                    end
                end

                // Low byte goes out alongside the gate release when possible.
                c_st_alu_wait: begin
                    if (ALU_Valid) begin
                        r_result    <= ALU_Out;
                        CLK_GATE_EN <= 1'b0;
                        if (!FIFO_Full) begin
                            FIFO_WrEn   <= 1'b1;
                            FIFO_WrData <= ALU_Out[DATA_WIDTH-1:0];
                            r_state     <= c_st_send_hi;
                        end else begin
                            r_state <= c_st_send_lo;
                        end
                    end
                end

                c_st_send_lo: begin
                    if (!FIFO_Full) begin
                        FIFO_WrEn   <= 1'b1;
                        FIFO_WrData <= r_result[DATA_WIDTH-1:0];
                        r_state     <= c_st_send_hi;
                    end
                end

                c_st_send_hi: begin
                    if (!FIFO_Full) begin
                        FIFO_WrEn   <= 1'b1;
                        FIFO_WrData <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_state     <= c_st_idle;
                    end
                end

                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_cntr_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_cntr_rx
// Brief    : Directed and randomized frame bench for sys_cntr_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_cntr_rx;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  RX_Data = '0;
    logic        RX_Valid = 1'b0;
    logic [3:0]  RF_Addr;
    logic        RF_WrEn;
    logic [7:0]  RF_WrData;
    logic        RF_RdEn;
    logic [7:0]  RF_RdData = '0;
    logic        RF_RdValid = 1'b0;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_Out = '0;
    logic        ALU_Valid = 1'b0;
    logic        CLK_GATE_EN;
    logic        FIFO_Full = 1'b0;
    logic [7:0]  FIFO_WrData;
    logic        FIFO_WrEn;

    sys_cntr_rx #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
        .CLK(CLK), .Reset(Reset), .RX_Data(RX_Data), .RX_Valid(RX_Valid),
        .RF_Addr(RF_Addr), .RF_WrEn(RF_WrEn), .RF_WrData(RF_WrData),
        .RF_RdEn(RF_RdEn), .RF_RdData(RF_RdData), .RF_RdValid(RF_RdValid),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_Out(ALU_Out), .ALU_Valid(ALU_Valid),
        .CLK_GATE_EN(CLK_GATE_EN), .FIFO_Full(FIFO_Full),
        .FIFO_WrData(FIFO_WrData), .FIFO_WrEn(FIFO_WrEn)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;
    logic full_at_edge = 1'b0;

    logic [11:0] wr_log[$];
    logic [3:0]  rd_log[$];
    logic [3:0]  alu_log[$];
    logic [7:0]  push_log[$];

    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_alu[$];
    logic [7:0]  exp_push[$];

    always @(posedge CLK) full_at_edge <= FIFO_Full;

    // Transaction monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RF_WrEn)   wr_log.push_back({RF_Addr, RF_WrData});
        if (RF_RdEn)   rd_log.push_back(RF_Addr);
        if (ALU_EN)    alu_log.push_back(ALU_FUN);
        if (FIFO_WrEn) push_log.push_back(FIFO_WrData);
        if (FIFO_WrEn && full_at_edge) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({RF_Addr, RF_WrEn, RF_WrData, RF_RdEn, ALU_EN, ALU_FUN,
                    CLK_GATE_EN, FIFO_WrData, FIFO_WrEn});
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK); RX_Data = b; RX_Valid = 1'b1;
        @(negedge CLK); RX_Valid = 1'b0;
    endtask

    task automatic rd_valid(input logic [7:0] d);
        @(negedge CLK); RF_RdData = d; RF_RdValid = 1'b1;
        @(negedge CLK); RF_RdValid = 1'b0;
    endtask

    task automatic alu_valid(input logic [15:0] r);
        @(negedge CLK); ALU_Out = r; ALU_Valid = 1'b1;
        @(negedge CLK); ALU_Valid = 1'b0;
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); alu_log.delete(); push_log.delete();
        exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_push.delete();
    endtask

    // Bounded wait for n pushes while the FIFO randomly asserts backpressure.
    task automatic drain(input int n);
        for (int i = 0; i < 80 && push_log.size() < n; i++) begin
            FIFO_Full = ($urandom_range(0, 2) == 0);
            @(negedge CLK);
        end
        FIFO_Full = 1'b0;
    endtask

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        do b = 8'($urandom);
        while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
        return b;
    endfunction

    initial begin
        int stalled;
        int bad;
        logic [7:0]  a, b, d, fn;
        logic [15:0] r;
        int kind;

        // Reset state
        Reset = 1'b0;
        idle(3);
        chk("reset_outs", outs(), 0);
        Reset = 1'b1;
        idle(2);

        // RF write
        clear_logs();
        send_byte(8'hAA); send_byte(8'h05);
        chk("wr_early", 32'(RF_WrEn), 0);
        send_byte(8'h3C);
        chk("wr_en", 32'(RF_WrEn), 1);
        chk("wr_addr", 32'(RF_Addr), 5);
        chk("wr_data", 32'(RF_WrData), 'h3C);
        idle(1);
        chk("wr_single", 32'(RF_WrEn), 0);
        idle(3);
        chk("wr_count", 32'(wr_log.size()), 1);
        chk("wr_no_push", 32'(push_log.size()), 0);

        // Unknown command ahead of a write
        clear_logs();
        send_byte(8'h77); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        chk("unk_wr_en", 32'(RF_WrEn), 1);
        chk("unk_wr_addr", 32'(RF_Addr), 1);
        chk("unk_wr_data", 32'(RF_WrData), 'h02);
        idle(3);
        chk("unk_wr_count", 32'(wr_log.size()), 1);

        // RF read with backpressure
        clear_logs();
        send_byte(8'hBB); send_byte(8'h07);
        chk("rd_en", 32'(RF_RdEn), 1);
        chk("rd_addr", 32'(RF_Addr), 7);
        idle(2);
        FIFO_Full = 1'b1;
        rd_valid(8'h9E);
        stalled = 0;
        repeat (5) begin
            if (FIFO_WrEn) stalled++;
            @(negedge CLK);
        end
        chk("rd_stall_nopush", 32'(stalled), 0);
        FIFO_Full = 1'b0;
        @(negedge CLK);
        chk("rd_push_en", 32'(FIFO_WrEn), 1);
        chk("rd_push_data", 32'(FIFO_WrData), 'h9E);
        idle(1);
        chk("rd_push_single", 32'(FIFO_WrEn), 0);
        rd_valid(8'h11);
        idle(3);
        chk("rd_stray_valid", 32'(push_log.size()), 1);

        // ALU with operands
        clear_logs();
        send_byte(8'hCC); send_byte(8'h12);
        chk("cc_wr0", 32'({RF_WrEn, RF_Addr, RF_WrData}), 32'({1'b1, 4'd0, 8'h12}));
        send_byte(8'h34);
        chk("cc_wr1", 32'({RF_WrEn, RF_Addr, RF_WrData}), 32'({1'b1, 4'd1, 8'h34}));
        send_byte(8'h01);
        chk("cc_alu_en", 32'({ALU_EN, ALU_FUN, CLK_GATE_EN}), 32'({1'b1, 4'd1, 1'b1}));
        bad = 0;
        repeat (3) begin
            @(negedge CLK);
            if (!CLK_GATE_EN || ALU_EN) bad++;
        end
        chk("cc_gate_hold", 32'(bad), 0);
        alu_valid(16'h0046);
        chk("cc_gate_fall", 32'(CLK_GATE_EN), 0);
        chk("cc_push_lo", 32'({FIFO_WrEn, FIFO_WrData}), 32'({1'b1, 8'h46}));
        @(negedge CLK);
        chk("cc_push_hi", 32'({FIFO_WrEn, FIFO_WrData}), 32'({1'b1, 8'h00}));
        @(negedge CLK);
        chk("cc_push_end", 32'(FIFO_WrEn), 0);
        chk("cc_fun_hold", 32'(ALU_FUN), 1);

        // ALU without operands, with a dropped byte
        clear_logs();
        send_byte(8'hDD); send_byte(8'h02);
        chk("dd_alu_en", 32'({ALU_EN, ALU_FUN, CLK_GATE_EN}), 32'({1'b1, 4'd2, 1'b1}));
        send_byte(8'h55);
        chk("dd_drop", 32'({RF_WrEn, RF_RdEn, ALU_EN, FIFO_WrEn, CLK_GATE_EN}), 32'(5'b00001));
        alu_valid(16'hABCD);
        chk("dd_push_lo", 32'({FIFO_WrEn, FIFO_WrData}), 32'({1'b1, 8'hCD}));
        @(negedge CLK);
        chk("dd_push_hi", 32'({FIFO_WrEn, FIFO_WrData}), 32'({1'b1, 8'hAB}));
        idle(3);
        chk("dd_push_count", 32'(push_log.size()), 2);
        chk("dd_no_wr", 32'(wr_log.size()), 0);

        // Reset mid-frame in ALU_WAIT
        clear_logs();
        send_byte(8'hDD); send_byte(8'h03);
        idle(2);
        @(negedge CLK); Reset = 1'b0;
        @(negedge CLK); Reset = 1'b1;
        chk("midrst_outs", outs(), 0);
        alu_valid(16'h1234);
        idle(2);
        chk("midrst_no_push", 32'(push_log.size()), 0);
        send_byte(8'hBB); send_byte(8'h04);
        chk("midrst_rd", 32'({RF_RdEn, RF_Addr}), 32'({1'b1, 4'd4}));
        rd_valid(8'h5A);
        chk("midrst_push", 32'({FIFO_WrEn, FIFO_WrData}), 32'({1'b1, 8'h5A}));
        idle(2);

        // Randomized frames against a frame-level model
        for (int f = 0; f < 40; f++) begin
            clear_logs();
            kind = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) send_byte(junk_byte());
            a  = 8'($urandom);
            b  = 8'($urandom);
            d  = 8'($urandom);
            fn = 8'($urandom);
            r  = 16'($urandom);
            case (kind)
                0: begin
                    send_byte(8'hAA); send_byte(a); send_byte(d);
                    exp_wr.push_back({a[3:0], d});
                end
                1: begin
                    send_byte(8'hBB); send_byte(a);
                    exp_rd.push_back(a[3:0]);
                    if ($urandom_range(0, 1) == 1) send_byte(junk_byte());
                    idle($urandom_range(0, 3));
                    FIFO_Full = 1'($urandom_range(0, 1));
                    rd_valid(d);
                    exp_push.push_back(d);
                    drain(1);
                end
                2, 3: begin
                    if (kind == 2) begin
                        send_byte(8'hCC); send_byte(a); send_byte(b);
                        exp_wr.push_back({4'd0, a});
                        exp_wr.push_back({4'd1, b});
                    end else begin
                        send_byte(8'hDD);
                    end
                    send_byte(fn);
                    exp_alu.push_back(fn[3:0]);
                    if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
                    idle($urandom_range(0, 3));
                    FIFO_Full = 1'($urandom_range(0, 1));
                    alu_valid(r);
                    exp_push.push_back(r[7:0]);
                    exp_push.push_back(r[15:8]);
                    drain(2);
                end
                default: send_byte(junk_byte());
            endcase
            FIFO_Full = 1'b0;
            idle(3);
            chk("rnd_gate_idle", 32'(CLK_GATE_EN), 0);
            chk("rnd_wr_n", 32'(wr_log.size()), 32'(exp_wr.size()));
            chk("rnd_rd_n", 32'(rd_log.size()), 32'(exp_rd.size()));
            chk("rnd_alu_n", 32'(alu_log.size()), 32'(exp_alu.size()));
            chk("rnd_push_n", 32'(push_log.size()), 32'(exp_push.size()));
            for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
                chk("rnd_wr", 32'(wr_log[i]), 32'(exp_wr[i]));
            for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
                chk("rnd_rd", 32'(rd_log[i]), 32'(exp_rd[i]));
            for (int i = 0; i < exp_alu.size() && i < alu_log.size(); i++)
                chk("rnd_alu", 32'(alu_log[i]), 32'(exp_alu[i]));
            for (int i = 0; i < exp_push.size() && i < push_log.size(); i++)
                chk("rnd_push", 32'(push_log[i]), 32'(exp_push[i]));
        end

        chk("no_push_while_full", 32'(viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
